drop_tick_scheduler: RTL and testbench

//  Generates the single-cycle gravity "tick" that moves the active Tetris piece down one row.

---
 rtl/drop_tick_scheduler.sv | 158 +++++++++++++++
 tb/tb_drop_tick_scheduler.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/drop_tick_scheduler.sv
// Gravity / soft-drop / hard-drop tick generator for the falling Tetris piece.
// Optional soft drop (keycode 0x51) is compiled in when SOFT_DROP_EN is defined.
module drop_tick_scheduler #(
    parameter int         BASE_FRAMES = 48,
    parameter int         LEVEL_STEP  = 4,
    parameter int         MIN_FRAMES  = 2,
    parameter int         SOFT_FRAMES = 2,
    parameter int         HARD_GAP    = 4,
    parameter int         LEVEL_W     = 4,
    parameter logic [2:0] ST_PLAY     = 3'b001,
    parameter logic [2:0] ST_SPAWN    = 3'b010
) (
    input  logic               Clk,
    input  logic               reset_n,
    input  logic               VGA_VS,
    input  logic [7:0]         keycode,
    input  logic [2:0]         state,
    input  logic [LEVEL_W-1:0] level,
    input  logic               landed,
    input  logic               pause,
    output logic               tick,
    output logic               hard_active,
    output logic [1:0]         mode
);

    localparam int GAP_W = (HARD_GAP > 2) ? $clog2(HARD_GAP) : 1;

    // Handshake: tick is a one-cycle strobe with no ready; the datapath must
    // consume it in the cycle it is high.
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GRAVITY = 2'b01,
        SOFT    = 2'b10,
        HARD    = 2'b11
    } mode_t;

    mode_t             mode_q, mode_n;
    logic [15:0]       frame_q, frame_n, frame_inc;
    logic [15:0]       level_prod, gravity_iv, active_iv;
    logic [GAP_W-1:0]  gap_q, gap_n;
    logic              hd_ready_q, hd_ready_n;
    logic              tick_n;
    logic              vs_s1, vs_s2, vs_s3;
    logic              frame_pulse;
    logic              key_hard, in_play;

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            vs_s1 <= 1'b0;
            vs_s2 <= 1'b0;
            vs_s3 <= 1'b0;
        end else begin
            vs_s1 <= VGA_VS;
            vs_s2 <= vs_s1;
            vs_s3 <= vs_s2;
        end
    end

    assign frame_pulse = vs_s2 & ~vs_s3;
    assign key_hard    = (keycode == 8'h2C);
    assign in_play     = (state == ST_PLAY);

    // Saturating interval: never below MIN_FRAMES, even when level*step overshoots.
    assign level_prod = 16'(level) * 16'(LEVEL_STEP);
    always_comb begin
        if ((level_prod >= 16'(BASE_FRAMES)) ||
            ((16'(BASE_FRAMES) - level_prod) < 16'(MIN_FRAMES)))
            gravity_iv = 16'(MIN_FRAMES);
        else
            gravity_iv = 16'(BASE_FRAMES) - level_prod;
    end

    always_comb begin
        mode_n     = mode_q;
        frame_n    = frame_q;
        gap_n      = gap_q;
        hd_ready_n = hd_ready_q;
        tick_n     = 1'b0;
        frame_inc  = frame_q + 16'd1;
        active_iv  = gravity_iv;
        if (!key_hard)
            hd_ready_n = 1'b1;
        case (mode_q)
            IDLE: begin
                if (in_play && !pause) begin
                    mode_n  = GRAVITY;
                    frame_n = 16'd0;
                end
            end
            GRAVITY, SOFT: begin
                if (!in_play) begin
                    mode_n = IDLE;
                end else if (!pause) begin
                    if (key_hard && hd_ready_q) begin
                        mode_n     = HARD;
                        hd_ready_n = 1'b0;
                        gap_n      = '0;
                    end else begin
`ifdef SOFT_DROP_EN
                        if (keycode == 8'h51) begin
                            mode_n    = SOFT;
                            active_iv = 16'(SOFT_FRAMES);
                        end else begin
                            mode_n    = GRAVITY;
                        end
`endif
                        // ">=" lets a shortened interval fire on the very next frame.
                        if (frame_pulse) begin
                            if (frame_inc >= active_iv) begin
                                tick_n  = 1'b1;
                                frame_n = 16'd0;
                            end else begin
                                frame_n = frame_inc;
                            end
                        end
                    end
                end
            end
            HARD: begin
                if (!in_play && (state != ST_SPAWN)) begin
                    mode_n = IDLE;
                end else if (!pause) begin
                    if (landed || (state == ST_SPAWN)) begin
                        mode_n  = GRAVITY;
                        frame_n = 16'd0;
                        gap_n   = '0;
                    end else if (gap_q == GAP_W'(HARD_GAP - 1)) begin
                        tick_n = 1'b1;
                        gap_n  = '0;
                    end else begin
                        gap_n = gap_q + 1'b1;
                    end
                end
            end
            default: mode_n = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_q     <= IDLE;
            frame_q    <= 16'd0;
            gap_q      <= '0;
            hd_ready_q <= 1'b1;
            tick       <= 1'b0;
        end else begin
            mode_q     <= mode_n;
            frame_q    <= frame_n;
            gap_q      <= gap_n;
            hd_ready_q <= hd_ready_n;
            tick       <= tick_n;
        end
    end

    assign mode        = mode_q;
    assign hard_active = (mode_q == HARD);

endmodule

// File: tb/tb_drop_tick_scheduler.sv
// Directed bench for drop_tick_scheduler: gravity, level saturation, pause, soft and hard drop, async reset.
module tb_drop_tick_scheduler;

`ifdef SOFT_DROP_EN
    localparam bit SOFT_EN = 1'b1;
`else
    localparam bit SOFT_EN = 1'b0;
`endif

    logic       Clk;
    logic       reset_n;
    logic       VGA_VS;
    logic [7:0] keycode;
    logic [2:0] state;
    logic [3:0] level;
    logic       landed;
    logic       pause;
    logic       tick;
    logic       hard_active;
    logic [1:0] mode;

    logic [31:0] cyc;
    logic [31:0] exp_q[$];
    int          pass_cnt;
    int          fail_cnt;
    int          total_cnt;
    int          mf;

    drop_tick_scheduler dut (
        .Clk         (Clk),
        .reset_n     (reset_n),
        .VGA_VS      (VGA_VS),
        .keycode     (keycode),
        .state       (state),
        .level       (level),
        .landed      (landed),
        .pause       (pause),
        .tick        (tick),
        .hard_active (hard_active),
        .mode        (mode)
    );

    // clock / cycle counter
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_iv(input int lv, input logic [7:0] key);
        int v;
        if (SOFT_EN && key == 8'h51) return 2;
        v = 48 - lv * 4;
        return (v < 2) ? 2 : v;
    endfunction

    // scoreboard: every tick must land on the next expected cycle
    always @(negedge Clk) begin
        if (exp_q.size() > 0 && exp_q[0] == cyc) begin
            void'(exp_q.pop_front());
            chk("tick_expected", 32'(tick), 32'd1);
        end else if (tick) begin
            chk("tick_spurious", 32'(tick), 32'd0);
        end
    end

    // one VS rising edge; predicts the resulting tick from the frame model
    task automatic vs_edge();
        @(negedge Clk);
        VGA_VS = 1'b1;
        if (!pause) begin
            mf++;
            if (mf >= model_iv(int'(level), keycode)) begin
                exp_q.push_back(cyc + 3);
                mf = 0;
            end
        end
        repeat (3) @(negedge Clk);
        VGA_VS = 1'b0;
        repeat (3) @(negedge Clk);
    endtask

    task automatic vs_edges(input int n);
        for (int i = 0; i < n; i++) vs_edge();
    endtask

    initial begin
        logic [31:0] c;
        pass_cnt = 0; fail_cnt = 0; total_cnt = 0; mf = 0;
        reset_n = 1'b0; VGA_VS = 1'b0; keycode = 8'h00; state = 3'b000;
        level = 4'd0; landed = 1'b0; pause = 1'b0;
        #23 reset_n = 1'b1;
        repeat (3) @(negedge Clk);
        chk("reset_mode", 32'(mode), 32'd0);
        chk("reset_tick", 32'(tick), 32'd0);
        chk("reset_hard", 32'(hard_active), 32'd0);

        // enter play -> GRAVITY
        state = 3'b001;
        @(negedge Clk);
        chk("enter_gravity", 32'(mode), 32'd1);

        // level 0: ticks after edges 48 and 96
        vs_edges(100);
        chk("gravity_mode", 32'(mode), 32'd1);

        // level 15 saturates to MIN_FRAMES; lower interval fires on next edge
        level = 4'd15;
        vs_edges(11);

        // pause freezes frame count and drops frame pulses
        level = 4'd3;
        vs_edges(10);
        pause = 1'b1;
        vs_edges(20);
        chk("pause_mode_hold", 32'(mode), 32'd1);
        pause = 1'b0;
        vs_edges(26);

        // soft drop pressed mid-count
        level = 4'd0;
        vs_edges(10);
        keycode = 8'h51;
        @(negedge Clk);
        chk("soft_mode", 32'(mode), SOFT_EN ? 32'd2 : 32'd1);
        vs_edge();
        keycode = 8'h00;
        @(negedge Clk);
        chk("soft_release_mode", 32'(mode), 32'd1);
        vs_edges(48);

        // hard drop: space held 200 clks, landed at clk 30
        @(negedge Clk);
        c = cyc;
        keycode = 8'h2C;
        for (int k = 5; k <= 29; k += 4) exp_q.push_back(c + k);
        @(negedge Clk);
        chk("hard_mode", 32'(mode), 32'd3);
        chk("hard_active", 32'(hard_active), 32'd1);
        repeat (29) @(negedge Clk);
        landed = 1'b1;
        @(negedge Clk);
        chk("hard_exit_mode", 32'(mode), 32'd1);
        chk("hard_exit_active", 32'(hard_active), 32'd0);
        chk("hard_exit_no_tick", 32'(tick), 32'd0);
        repeat (80) @(negedge Clk);
        chk("no_rehard_mid", 32'(mode), 32'd1);
        repeat (89) @(negedge Clk);
        chk("no_rehard_end", 32'(mode), 32'd1);
        keycode = 8'h00;
        landed = 1'b0;
        mf = 0;
        @(negedge Clk);

        // new hard drop after release, then async reset mid-HARD
        keycode = 8'h2C;
        @(negedge Clk);
        chk("rehard_mode", 32'(mode), 32'd3);
        repeat (2) @(negedge Clk);
        #3 reset_n = 1'b0;
        #1;
        chk("async_rst_tick", 32'(tick), 32'd0);
        chk("async_rst_mode", 32'(mode), 32'd0);
        chk("async_rst_hard", 32'(hard_active), 32'd0);
        keycode = 8'h00;
        repeat (2) @(negedge Clk);
        reset_n = 1'b1;
        @(negedge Clk);
        chk("post_rst_gravity", 32'(mode), 32'd1);
        repeat (10) @(negedge Clk);
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
